// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction memory loader.
package inst_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_DONE     = 2'd1,
        ST_OVERFLOW = 2'd2
    } load_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_STEP      = 4;
    localparam logic [31:0] HALT_OPCODE    = 32'hFFFF_FFFF;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte stream in, instruction memory write port and load status out.
interface inst_mem_loader_if #(
    parameter int NBITS = 32
);
    logic [7:0]       i_rx_data;
    logic             i_rx_valid;
    logic             i_clear;
    logic             o_inst_mem_wr_en;
    logic [NBITS-1:0] o_inst_mem_data;
    logic [NBITS-1:0] o_inst_mem_addr;
    logic             o_load_done;
    logic             o_overflow;
    logic [NBITS-1:0] o_word_count;

    // master: byte source / memory side; slave: the loader itself
    modport master (
        output i_rx_data, i_rx_valid, i_clear,
        input  o_inst_mem_wr_en, o_inst_mem_data, o_inst_mem_addr,
               o_load_done, o_overflow, o_word_count
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_clear,
        output o_inst_mem_wr_en, o_inst_mem_data, o_inst_mem_addr,
               o_load_done, o_overflow, o_word_count
    );
endinterface

// File: rtl/inst_mem_loader_byte_word_assembler.sv
// Big-endian byte-to-word shifter; word_valid pulses with the 4th byte of a word.
module byte_word_assembler
    import inst_mem_loader_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [NBITS-1:0] word,
    output logic             word_valid
);

    logic [1:0]       byte_cnt;
    logic [NBITS-1:0] shift;
    logic             accept;

    assign accept     = rx_valid & enable & ~clear;
    assign word       = {shift[NBITS-9:0], rx_data};
    assign word_valid = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt <= '0;
            shift    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            shift    <= '0;
        end else if (accept) begin
            shift    <= word;
            byte_cnt <= word_valid ? '0 : byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a byte stream into instruction memory until HALT is stored or memory fills.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               MEM_DEPTH = 256,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_OPCODE)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    inst_mem_loader_if.slave  bus
);

    load_state_t      state;
    logic             wr_pending;
    logic [NBITS-1:0] wr_data;
    logic [NBITS-1:0] wr_addr;
    logic [NBITS-1:0] word_count;
    logic             load_done;
    logic             overflow;
    logic [NBITS-1:0] asm_word;
    logic             asm_valid;

    byte_word_assembler #(
        .NBITS(NBITS)
    ) u_asm (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (bus.i_clear),
        .enable    (state == ST_LOAD),
        .rx_data   (bus.i_rx_data),
        .rx_valid  (bus.i_rx_valid),
        .word      (asm_word),
        .word_valid(asm_valid)
    );

    // Reset or clear arriving in the strobe cycle cancels that write immediately.
    assign bus.o_inst_mem_wr_en = wr_pending & i_rst & ~bus.i_clear;
    assign bus.o_inst_mem_data  = wr_data;
    assign bus.o_inst_mem_addr  = wr_addr;
    assign bus.o_load_done      = load_done;
    assign bus.o_overflow       = overflow;
    assign bus.o_word_count     = word_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= ST_LOAD;
            wr_pending <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
        end else if (bus.i_clear) begin
            state      <= ST_LOAD;
            wr_pending <= 1'b0;
            wr_addr    <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_pending <= asm_valid;
            if (asm_valid) begin
                wr_data <= asm_word;
            end
            case (state)
                ST_LOAD: begin
                    if (wr_pending) begin
                        wr_addr    <= wr_addr + NBITS'(ADDR_STEP);
                        word_count <= word_count + NBITS'(1);
                        if (wr_data == HALT_WORD) begin
                            state     <= ST_DONE;
                            load_done <= 1'b1;
                        end else if (word_count == NBITS'(MEM_DEPTH - 1)) begin
                            state    <= ST_OVERFLOW;
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_DONE:     state <= ST_DONE;
                ST_OVERFLOW: state <= ST_OVERFLOW;
                default:     state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Upstream of the fetch stage: takes bytes from the UART receiver, assembles them into 32-bit instructions and writes them sequentially into instruction memory. It drives the memory write enable, write data and write address seen by the fetch stage. It holds the CPU in load mode until the program's HALT word has been stored, then signals completion so the pipeline can be released.

## Interface
- NBITS, 32: instruction/data and address width.
- MEM_DEPTH, 256: instruction memory depth in words.
- HALT_WORD, 32'hFFFF_FFFF: end-of-program marker.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset, synchronous, active-low (0 = reset).
- i_rx_data  in  8  received byte, valid only while i_rx_valid=1.
- i_rx_valid  in  1  one-cycle strobe per received byte.
- i_clear  in  1  re-arm loader: discard progress, restart at address 0.
- o_inst_mem_wr_en  out  1  one-cycle write strobe to instruction memory.
- o_inst_mem_data  out  NBITS  assembled instruction word.
- o_inst_mem_addr  out  NBITS  byte address of the word being written; multiple of 4.
- o_load_done  out  1  high after HALT_WORD is written; CPU may run.
- o_overflow  out  1  high when memory filled without HALT_WORD.
- o_word_count  out  NBITS  number of words written since reset/clear.

## Operation
- States: LOAD, DONE, OVERFLOW. Reset and i_clear go to LOAD.
- LOAD: each i_rx_valid byte is shifted in, first byte = bits [31:24] (big-endian). Byte counter 0..3.
- On the 4th byte, the word is latched into the write register and the counter returns to 0. The next cycle carries the write: o_inst_mem_wr_en=1 with data and address.
- After each write, the address is incremented by 4 and o_word_count by 1.
- Transition decided on the write cycle, taking effect the following cycle:
  - word == HALT_WORD → DONE. The HALT word itself is written.
  - word != HALT_WORD at word index MEM_DEPTH-1 → OVERFLOW.
  - HALT_WORD at index MEM_DEPTH-1 → DONE, not OVERFLOW.
- DONE / OVERFLOW: i_rx_valid is ignored and no writes occur. o_load_done or o_overflow stays high until i_clear or reset.
- i_clear in any state: byte counter 0, address 0, o_word_count 0, partial word discarded, flags cleared. A pending write in the same cycle is cancelled.
- i_rst has priority over i_clear.

## Timing
- Reset values: o_inst_mem_wr_en=0, o_inst_mem_data=0, o_inst_mem_addr=0, o_load_done=0, o_overflow=0, o_word_count=0, state LOAD.
- Latency: 4th byte sampled in cycle N → write strobe in cycle N+1 → address/count updated and flags visible in cycle N+2.
- A byte arriving in the write cycle (N+1) is accepted as byte 0 of the next word. No byte is dropped at any back-to-back rate, including 1 byte/cycle.
- o_inst_mem_data and o_inst_mem_addr are stable throughout the strobe cycle. Outside the strobe they hold their last values.
- Address wrap is impossible: OVERFLOW stops writes before index MEM_DEPTH.

## Structure
- Shared package holds the state encoding (LOAD/DONE/OVERFLOW), BYTES_PER_WORD=4, ADDR_STEP=4 and the default HALT opcode constant.
- One natural sub-module: byte_word_assembler (shift register, 2-bit byte counter, word_valid pulse). The loader FSM, address and count registers live in the top.

## Test plan
- Reset: drive i_rst=0 for 2 cycles → all outputs 0, state LOAD.
- Bytes 8'h20,8'h08,8'h00,8'h05 → one strobe, data 32'h2008_0005, addr 0. Count becomes 1 two cycles after the last byte.
- Stream 3 words at 1 byte/cycle, then FF,FF,FF,FF → 4 writes at addrs 0,4,8,12. o_load_done=1 after the 4th write, count 4. Extra bytes produce no writes.
- MEM_DEPTH=4, 4 non-HALT words → o_overflow=1, o_load_done=0, last addr 12. Further bytes ignored.
- 2 bytes, then i_clear, then 4 bytes 8'hAA,8'hBB,8'hCC,8'hDD → single write 32'hAABB_CCDD at addr 0.
- i_rst=0 asserted in the write cycle → no strobe that cycle, all outputs 0 on the next cycle.
